// File: rtl/lsu_pkg.sv
// Shared constants for the load/store memory initiator: funct3 codes,
// sign_mask descriptor bits and FSM state encoding.
// Bit meanings of sign_mask: [3] sign-extend, [2] word, [1] half-or-word, [0] always 1.
package lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory access descriptor building blocks
  localparam logic [3:0] SIGN_MASK_BYTE = 4'b0001;
  localparam logic [3:0] SIGN_MASK_HALF = 4'b0011;
  localparam logic [3:0] SIGN_MASK_WORD = 4'b0111;
  localparam logic [3:0] SIGN_MASK_SEXT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_sign_mask_dec.sv
// Purpose: decode funct3/we into the memory sign_mask and flag illegal or misaligned requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the request inputs.
module lsu_sign_mask_dec
  import lsu_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_we,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic       o_illegal,
  output logic       o_misaligned
);

  // Map funct3 to the access descriptor; unsupported combinations are illegal
  always_comb begin
    o_sign_mask = '0;
    o_illegal   = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    o_sign_mask = SIGN_MASK_BYTE;
        F3_H:    o_sign_mask = SIGN_MASK_HALF;
        F3_W:    o_sign_mask = SIGN_MASK_WORD;
        default: o_illegal   = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B:    o_sign_mask = SIGN_MASK_BYTE | SIGN_MASK_SEXT;
        F3_H:    o_sign_mask = SIGN_MASK_HALF | SIGN_MASK_SEXT;
        F3_W:    o_sign_mask = SIGN_MASK_WORD;
        F3_BU:   o_sign_mask = SIGN_MASK_BYTE;
        F3_HU:   o_sign_mask = SIGN_MASK_HALF;
        default: o_illegal   = 1'b1;
      endcase
    end
  end

  // Word needs addr[1:0]==0, halfword needs addr[0]==0; bytes are always aligned
  always_comb begin
    o_misaligned = 1'b0;
    if (!o_illegal) begin
      if (o_sign_mask[2])
        o_misaligned = |i_addr_lo;
      else if (o_sign_mask[1])
        o_misaligned = i_addr_lo[0];
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Purpose: issue one load/store to data memory, track clk_stall rise/fall, return data or fault.
// Latency: 5 cycles accept-to-response nominal; decode faults respond next cycle; timeout after TIMEOUT_CYCLES wait cycles.
// Backpressure: req_ready only in IDLE, no queueing. LSU_MISALIGN_CHECK_EN enables misalignment faults.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_memwrite,
  output logic        o_mem_memread,
  output logic [3:0]  o_mem_sign_mask,
  input  logic [31:0] i_mem_read_data,
  input  logic        i_mem_clk_stall
);

  localparam int              CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHECK = 1'b1;
`else
  localparam bit MISALIGN_CHECK = 1'b0;
`endif

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_is_load;

  logic [3:0]       w_sign_mask;
  logic             w_illegal;
  logic             w_misaligned;
  logic             w_req_fault;
  logic             w_accept;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             w_timeout;

  lsu_sign_mask_dec u_dec (
    .i_funct3     (i_req_funct3),
    .i_we         (i_req_we),
    .i_addr_lo    (i_req_addr[1:0]),
    .o_sign_mask  (w_sign_mask),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned)
  );

  assign w_req_fault    = w_illegal | (MISALIGN_CHECK & w_misaligned);
  assign o_req_ready    = (r_state == IDLE);
  assign w_accept       = i_req_valid & o_req_ready;
  // The stored count never exceeds TIMEOUT_CYCLES-1, so the increment cannot wrap
  assign w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
  assign w_timeout      = (w_wait_cnt_nxt >= TIMEOUT_VAL);

  // Request FSM: accept, one-cycle strobe, wait for stall rise then fall, respond
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= IDLE;
      r_wait_cnt       <= '0;
      r_is_load        <= 1'b0;
      o_resp_valid     <= 1'b0;
      o_resp_rdata     <= '0;
      o_resp_fault     <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_write_data <= '0;
      o_mem_memwrite   <= 1'b0;
      o_mem_memread    <= 1'b0;
      o_mem_sign_mask  <= '0;
    end else begin
      o_resp_valid   <= 1'b0;
      o_resp_rdata   <= '0;
      o_resp_fault   <= 1'b0;
      o_mem_memwrite <= 1'b0;
      o_mem_memread  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_req_fault) begin
              // Rejected at decode: nothing reaches memory
              o_resp_valid <= 1'b1;
              o_resp_fault <= 1'b1;
            end else begin
              o_mem_addr       <= i_req_addr;
              o_mem_write_data <= i_req_wdata;
              o_mem_sign_mask  <= w_sign_mask;
              o_mem_memwrite   <= i_req_we;
              o_mem_memread    <= ~i_req_we;
              r_is_load        <= ~i_req_we;
              r_state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (w_timeout) begin
            o_resp_valid <= 1'b1;
            o_resp_fault <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (i_mem_clk_stall)
              r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_mem_clk_stall) begin
            o_resp_valid <= 1'b1;
            o_resp_rdata <= r_is_load ? i_mem_read_data : 32'd0;
            r_state      <= IDLE;
          end else if (w_timeout) begin
            o_resp_valid <= 1'b1;
            o_resp_fault <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
